hazard_control_unit: RTL

Central hazard controller for the 5-stage RISC-V pipeline. It detects load-use hazards between ID and EX and handles taken branches resolved in EX. It drives the PC write enable, the IF/ID write enable and flush, and the `FlushSignal` input of the ID/EX register, which turns the EX-bound control bits into a bubble. It sits beside the ID stage and is the producer side of the ID/EX flush interface.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/load_use_detect.sv | 29 ++
 rtl/hazard_control_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use comparator between the EX and ID stages.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import hazard_pkg::*;
(
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_uses_rs1,
  input  logic                 ifid_uses_rs2,
  output logic                 load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = ifid_uses_rs1 && (ifid_rs1 == idex_rd);
  assign w_rs2_hit = ifid_uses_rs2 && (ifid_rs2 == idex_rd);

  // x0 is hard-wired to zero, so a load into it never produces a dependency
  assign load_use  = idex_memread && (idex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Load-use stall and taken-branch flush controller for the
//               5-stage pipeline. Optional perf counters: HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_uses_rs1,
  input  logic                 ifid_uses_rs2,
  input  logic                 ex_branch_taken,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  localparam logic [3:0] C_FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         C_MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_param_check
    $error("hazard_control_unit: FLUSH_CYCLES must be 1..15 and CNT_W >= 1");
  end

  hz_state_t  r_state;
  hz_state_t  w_state_nxt;
  logic [3:0] r_fcnt;
  logic [3:0] w_fcnt_nxt;
  logic       w_load_use;

  load_use_detect u_load_use_detect (
    .idex_memread  (idex_memread),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs1 (ifid_uses_rs1),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .load_use      (w_load_use)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= HZ_RUN;
      r_fcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    if (!reset_n) begin
      // Hold fetch and fill both pipeline registers with bubbles
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      w_state_nxt = HZ_RUN;
      w_fcnt_nxt  = 4'd0;
    end else begin
      case (r_state)
        HZ_RUN, HZ_STALL: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (C_MULTI_FLUSH) begin
              w_state_nxt = HZ_FLUSH;
              w_fcnt_nxt  = C_FLUSH_RELOAD;
            end else begin
              w_state_nxt = HZ_RUN;
            end
          end else if (r_state == HZ_RUN && w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            w_state_nxt = HZ_STALL;
          end else begin
            w_state_nxt = HZ_RUN;
          end
        end
        HZ_FLUSH: begin
          // Instructions in ID/EX are wrong-path here, so hazards are ignored
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          w_fcnt_nxt = r_fcnt - 4'd1;
          if (r_fcnt <= 4'd1) begin
            w_state_nxt = HZ_RUN;
          end
        end
        default: begin
          w_state_nxt = HZ_RUN;
          w_fcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             w_stall_enter;
  logic             w_branch_accept;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_stall_enter   = (r_state == HZ_RUN) && !ex_branch_taken && w_load_use;
  assign w_branch_accept = (r_state != HZ_FLUSH) && ex_branch_taken;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_enter && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_branch_accept && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
